// File: rtl/uart_rx_ctrl_gen.sv
// UART receive controller: 2-flop synchronizer, 3-sample majority vote, LSB-first
// deserializer with parity/start/stop checking and per-frame captured configuration.
module uart_rx_ctrl_gen #(
  parameter int DATA_WIDTH  = 8,
  parameter int PRESC_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_in,
  input  logic [PRESC_WIDTH-1:0] prescale,
  input  logic                   par_en,
  input  logic                   par_typ,
  input  logic                   stop2,
  output logic [DATA_WIDTH-1:0]  p_data,
  output logic                   data_valid,
  output logic                   par_error,
  output logic                   stop_error,
  output logic                   strt_glitch,
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic                   r_sync1, r_sync2;
  logic [PRESC_WIDTH-1:0] r_presc, r_edge_cnt;
  logic [3:0]             r_bit_cnt;
  logic                   r_par_en, r_par_typ, r_stop2;
  logic                   r_samp0, r_samp1;
  logic [DATA_WIDTH-1:0]  r_shift;
  logic                   r_parity, r_par_flag, r_stop_flag;
  logic [DATA_WIDTH-1:0]  r_p_data;
  logic                   r_data_valid, r_par_error, r_stop_error, r_strt_glitch;

  logic                   w_rxs;
  logic [PRESC_WIDTH-1:0] w_presc_in, w_half;
  logic                   w_last, w_samp0_pt, w_samp1_pt, w_resolve, w_maj;
  logic                   w_start_entry;

  assign w_rxs      = r_sync2;
  assign w_presc_in = (prescale < PRESC_WIDTH'(4)) ? PRESC_WIDTH'(4) : prescale;
  assign w_half     = r_presc >> 1;
  assign w_last     = (r_edge_cnt == r_presc - PRESC_WIDTH'(1));
  assign w_samp0_pt = (r_edge_cnt == w_half - PRESC_WIDTH'(1));
  assign w_samp1_pt = (r_edge_cnt == w_half);
  assign w_resolve  = (r_edge_cnt == w_half + PRESC_WIDTH'(1));
  // Third sample is the live synchronized line, so the vote resolves at M+1 itself.
  assign w_maj      = (r_samp0 & r_samp1) | (r_samp0 & w_rxs) | (r_samp1 & w_rxs);

  assign w_start_entry = (w_next == S_START) && (r_state != S_START);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (!w_rxs) w_next = S_START;
      S_START: begin
        if (w_resolve && w_maj) w_next = S_IDLE;
        else if (w_last)        w_next = S_DATA;
      end
      S_DATA:
        if (w_last && (r_bit_cnt == 4'(DATA_WIDTH - 1)))
          w_next = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_last) w_next = S_STOP;
      S_STOP:
        if (w_resolve && (!r_stop2 || (r_bit_cnt == 4'd1))) w_next = S_DONE;
      S_DONE:   w_next = w_rxs ? S_IDLE : S_START;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1       <= 1'b1;
      r_sync2       <= 1'b1;
      r_presc       <= PRESC_WIDTH'(4);
      r_edge_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_par_en      <= 1'b0;
      r_par_typ     <= 1'b0;
      r_stop2       <= 1'b0;
      r_samp0       <= 1'b1;
      r_samp1       <= 1'b1;
      r_shift       <= '0;
      r_parity      <= 1'b0;
      r_par_flag    <= 1'b0;
      r_stop_flag   <= 1'b0;
      r_p_data      <= '0;
      r_data_valid  <= 1'b0;
      r_par_error   <= 1'b0;
      r_stop_error  <= 1'b0;
      r_strt_glitch <= 1'b0;
    end else begin
      r_sync1       <= rx_in;
      r_sync2       <= r_sync1;
      r_data_valid  <= 1'b0;
      r_par_error   <= 1'b0;
      r_stop_error  <= 1'b0;
      r_strt_glitch <= 1'b0;

      if (w_start_entry) begin
        r_presc     <= w_presc_in;
        r_par_en    <= par_en;
        r_par_typ   <= par_typ;
        r_stop2     <= stop2;
        r_edge_cnt  <= '0;
        r_bit_cnt   <= '0;
        r_parity    <= 1'b0;
        r_par_flag  <= 1'b0;
        r_stop_flag <= 1'b0;
      end else if (r_state == S_IDLE || r_state == S_DONE) begin
        r_edge_cnt <= '0;
        r_bit_cnt  <= '0;
      end else begin
        if (w_last || w_next == S_IDLE || w_next == S_DONE) r_edge_cnt <= '0;
        else                                                r_edge_cnt <= r_edge_cnt + PRESC_WIDTH'(1);
        if (w_samp0_pt) r_samp0 <= w_rxs;
        if (w_samp1_pt) r_samp1 <= w_rxs;
        case (r_state)
          S_START: if (w_resolve && w_maj) r_strt_glitch <= 1'b1;
          S_DATA: begin
            if (w_resolve) begin
              r_shift  <= {w_maj, r_shift[DATA_WIDTH-1:1]};
              r_parity <= r_parity ^ w_maj;
            end
            if (w_last) r_bit_cnt <= (w_next == S_DATA) ? r_bit_cnt + 4'd1 : 4'd0;
          end
          S_PARITY: if (w_resolve) r_par_flag <= w_maj ^ r_parity ^ r_par_typ;
          S_STOP: begin
            if (w_resolve && !w_maj) r_stop_flag <= 1'b1;
            if (w_last)              r_bit_cnt   <= r_bit_cnt + 4'd1;
          end
          default: ;
        endcase
      end

      if (r_state == S_DONE) begin
        if (!r_par_flag && !r_stop_flag) begin
          r_p_data     <= r_shift;
          r_data_valid <= 1'b1;
        end else begin
          r_par_error  <= r_par_flag;
          r_stop_error <= r_stop_flag;
        end
      end
    end
  end

  assign p_data      = r_p_data;
  assign data_valid  = r_data_valid;
  assign par_error   = r_par_error;
  assign stop_error  = r_stop_error;
  assign strt_glitch = r_strt_glitch;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl_gen.sv
// Scoreboard bench for uart_rx_ctrl_gen: directed frames push expected events,
// negedge monitors pop and compare whenever a DUT raises any pulse output.
module tb_uart_rx_ctrl_gen;

  localparam logic [3:0] K_VALID  = 4'b0001;
  localparam logic [3:0] K_PAR    = 4'b0010;
  localparam logic [3:0] K_STOP   = 4'b0100;
  localparam logic [3:0] K_GLITCH = 4'b1000;

  typedef struct packed {
    logic [3:0] kind;
    logic [8:0] data;
  } exp_t;

  exp_t q8[$];
  exp_t q5[$];
  int   tests = 0;
  int   fails = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx8, rx5;
  logic [5:0] presc8, presc5;
  logic       par_en8, par_typ8, stop2_8;
  logic       par_en5, par_typ5, stop2_5;
  logic [7:0] p_data8;
  logic [4:0] p_data5;
  logic       valid8, perr8, serr8, glitch8, busy8;
  logic       valid5, perr5, serr5, glitch5, busy5;

  always #5 clk = ~clk;

  uart_rx_ctrl_gen #(.DATA_WIDTH(8), .PRESC_WIDTH(6)) dut8 (
    .clk(clk), .rst(rst_n), .rx_in(rx8), .prescale(presc8),
    .par_en(par_en8), .par_typ(par_typ8), .stop2(stop2_8),
    .p_data(p_data8), .data_valid(valid8), .par_error(perr8),
    .stop_error(serr8), .strt_glitch(glitch8), .busy(busy8)
  );

  uart_rx_ctrl_gen #(.DATA_WIDTH(5), .PRESC_WIDTH(6)) dut5 (
    .clk(clk), .rst(rst_n), .rx_in(rx5), .prescale(presc5),
    .par_en(par_en5), .par_typ(par_typ5), .stop2(stop2_5),
    .p_data(p_data5), .data_valid(valid5), .par_error(perr5),
    .stop_error(serr5), .strt_glitch(glitch5), .busy(busy5)
  );

  always @(negedge clk) begin
    logic [3:0] k;
    exp_t e;
    k = {glitch8, serr8, perr8, valid8};
    if (k != 4'b0000) begin
      tests++;
      if (q8.size() == 0) begin
        fails++;
        $display("FAIL dut8_event: got kind=%b p_data=%h, required no event", k, p_data8);
      end else begin
        e = q8.pop_front();
        if (k !== e.kind || p_data8 !== e.data[7:0]) begin
          fails++;
          $display("FAIL dut8_event: got kind=%b p_data=%h, required kind=%b p_data=%h",
                   k, p_data8, e.kind, e.data[7:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] k;
    exp_t e;
    k = {glitch5, serr5, perr5, valid5};
    if (k != 4'b0000) begin
      tests++;
      if (q5.size() == 0) begin
        fails++;
        $display("FAIL dut5_event: got kind=%b p_data=%h, required no event", k, p_data5);
      end else begin
        e = q5.pop_front();
        if (k !== e.kind || p_data5 !== e.data[4:0]) begin
          fails++;
          $display("FAIL dut5_event: got kind=%b p_data=%h, required kind=%b p_data=%h",
                   k, p_data5, e.kind, e.data[4:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input bit sel5, input logic v);
    if (sel5) rx5 = v;
    else      rx8 = v;
  endtask

  // bits[0] goes on the line first: start, data LSB first, optional parity, stop(s)
  task automatic send(input bit sel5, input logic [8:0] d, input int nb,
                      input bit has_par, input logic pb,
                      input logic s1, input bit two, input logic s2, input int bitlen);
    logic [15:0] bits;
    int n;
    bits = '1;
    bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < nb; i++) begin
      bits[n] = d[i];
      n++;
    end
    if (has_par) begin
      bits[n] = pb;
      n++;
    end
    bits[n] = s1;
    n++;
    if (two) begin
      bits[n] = s2;
      n++;
    end
    for (int i = 0; i < n; i++) begin
      set_rx(sel5, bits[i]);
      tick(bitlen);
    end
    set_rx(sel5, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    rx8 = 1'b1; rx5 = 1'b1;
    presc8 = 6'd8; par_en8 = 1'b0; par_typ8 = 1'b0; stop2_8 = 1'b0;
    presc5 = 6'd5; par_en5 = 1'b1; par_typ5 = 1'b1; stop2_5 = 1'b0;
    tick(3);
    chk("reset_p_data8", 16'(p_data8), 16'h0);
    chk("reset_pulses8", 16'({valid8, perr8, serr8, glitch8}), 16'h0);
    chk("reset_busy8", 16'(busy8), 16'h0);
    chk("reset_p_data5", 16'(p_data5), 16'h0);
    chk("reset_busy5", 16'(busy5), 16'h0);
    rst_n = 1'b1;
    tick(5);

    // P=8, no parity, one stop
    q8.push_back({K_VALID, 9'h0A5});
    send(0, 9'h0A5, 8, 0, 1'b0, 1'b1, 0, 1'b1, 8);
    tick(16);

    // P=16 even parity: wrong parity bit, then correct one
    presc8 = 6'd16; par_en8 = 1'b1; par_typ8 = 1'b0;
    q8.push_back({K_PAR, 9'h0A5});
    send(0, 9'h03C, 8, 1, 1'b1, 1'b1, 0, 1'b1, 16);
    tick(32);
    q8.push_back({K_VALID, 9'h03C});
    send(0, 9'h03C, 8, 1, 1'b0, 1'b1, 0, 1'b1, 16);
    tick(32);

    // 3-cycle low pulse is a false start
    par_en8 = 1'b0;
    q8.push_back({K_GLITCH, 9'h03C});
    rx8 = 1'b0;
    tick(3);
    chk("glitch_busy8", 16'(busy8), 16'h1);
    rx8 = 1'b1;
    tick(40);
    chk("glitch_idle8", 16'(busy8), 16'h0);

    // P=32 two stop bits, back-to-back frames
    presc8 = 6'd32; stop2_8 = 1'b1;
    q8.push_back({K_VALID, 9'h055});
    q8.push_back({K_VALID, 9'h0AA});
    send(0, 9'h055, 8, 0, 1'b0, 1'b1, 1, 1'b1, 32);
    send(0, 9'h0AA, 8, 0, 1'b0, 1'b1, 1, 1'b1, 32);
    tick(64);
    q8.push_back({K_STOP, 9'h0AA});
    q8.push_back({K_VALID, 9'h00F});
    send(0, 9'h055, 8, 0, 1'b0, 1'b1, 1, 1'b0, 32);
    send(0, 9'h00F, 8, 0, 1'b0, 1'b1, 1, 1'b1, 32);
    tick(64);

    // P=2 clamps to 4
    presc8 = 6'd2; stop2_8 = 1'b0;
    q8.push_back({K_VALID, 9'h06B});
    send(0, 9'h06B, 8, 0, 1'b0, 1'b1, 0, 1'b1, 4);
    tick(16);

    // DATA_WIDTH=5, P=5, odd parity
    q5.push_back({K_VALID, 9'h013});
    send(1, 9'h013, 5, 1, 1'b0, 1'b1, 0, 1'b1, 5);
    tick(15);
    q5.push_back({K_PAR, 9'h013});
    send(1, 9'h013, 5, 1, 1'b1, 1'b1, 0, 1'b1, 5);
    tick(15);

    // Reset in the middle of DATA aborts the frame silently
    presc8 = 6'd8;
    rx8 = 1'b0; tick(8);
    rx8 = 1'b1; tick(8);
    rx8 = 1'b0; tick(16);
    chk("middata_busy8", 16'(busy8), 16'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_p_data8", 16'(p_data8), 16'h0);
    chk("midrst_pulses8", 16'({valid8, perr8, serr8, glitch8}), 16'h0);
    chk("midrst_busy8", 16'(busy8), 16'h0);
    rx8 = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    q8.push_back({K_VALID, 9'h081});
    send(0, 9'h081, 8, 0, 1'b0, 1'b1, 0, 1'b1, 8);

    for (int i = 0; i < 200 && (q8.size() != 0 || q5.size() != 0); i++) tick(1);
    tick(4);
    chk("pending_events8", 16'(q8.size()), 16'h0);
    chk("pending_events5", 16'(q5.size()), 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl_gen.md
Name: uart_rx_ctrl_gen

Overview:
Parametrised UART receive controller, the next generation of the RX control path. It integrates the FSM, the edge and bit counters, a majority-vote sampler, the deserializer and the parity, start and stop checkers in one block. It supports any prescale from 4 to 63, a configurable data width, even or odd parity, and one or two stop bits. It sits between the RX pad synchronizer domain and the SYS_CTRL frame consumer, in the UART RX clock domain.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (5..9), LSB first.
PRESC_WIDTH, 6, width of the prescale and edge counter.

Ports:
clk  in  1  RX oversampling clock.
rst  in  1  asynchronous active-low reset.
rx_in  in  1  serial line, idle high. Passes through an internal 2-flop synchronizer.
prescale  in  PRESC_WIDTH  oversampling ratio, captured at frame start.
par_en  in  1  parity bit present. Captured at frame start.
par_typ  in  1  0 = even, 1 = odd. Captured at frame start.
stop2  in  1  two stop bits. Captured at frame start.
p_data  out  DATA_WIDTH  last good frame payload.
data_valid  out  1  one-cycle pulse: good frame.
par_error  out  1  one-cycle pulse: parity mismatch.
stop_error  out  1  one-cycle pulse: a stop bit sampled 0.
strt_glitch  out  1  one-cycle pulse: false start.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state IDLE; all counters 0; p_data 0; all pulse outputs 0; busy 0; synchronizer flops 1. Reset mid-frame aborts the frame with no pulses.
- rxs is the synchronized rx_in, delayed 2 clk from the pin.
- Prescale handling:
  - The effective prescale P is the captured value. Values below 4 clamp to 4.
  - M = P>>1 (floor, so odd P is legal).
  - Mid-frame changes to prescale, par_en, par_typ or stop2 have no effect on the current frame.
- Bit timing:
  - edge_cnt runs 0..P-1 per bit and wraps to 0 at P-1.
  - bit_cnt increments on each wrap.
  - Samples are taken at edge_cnt M-1, M and M+1.
  - The majority of the 3 samples is the bit value, resolved in the cycle edge_cnt==M+1.
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE:
  - When rxs==0, go to START with edge_cnt=0. The configuration inputs are captured in this same cycle.
- START:
  - At resolve, if the start bit is 1: strt_glitch pulses next cycle and the FSM goes to IDLE.
  - Otherwise stay in START until edge_cnt==P-1, then go to DATA with bit_cnt=0.
- DATA:
  - At each resolve, shift the bit into the MSB of the shift register (right shift, LSB first).
  - Running parity is the XOR of the data bits.
  - When bit_cnt==DATA_WIDTH-1 and edge_cnt==P-1, go to PARITY if par_en, else STOP.
- PARITY:
  - At resolve, the parity error flag = sampled bit XOR (running parity XOR par_typ).
  - At edge_cnt==P-1, go to STOP.
- STOP:
  - With stop2=0: one stop bit. The decision is made at the resolve of that bit.
  - With stop2=1: the first stop bit lasts a full P cycles, then the second bit is decided at its resolve.
  - Any stop sample of 0 sets the stop error flag.
  - At the decision cycle, go to DONE. The early exit lets a back-to-back start edge at M+2 cycles be caught.
- DONE (exactly 1 cycle):
  - With no error flag: p_data <= shift register and data_valid=1.
  - Otherwise par_error and/or stop_error pulse for the flags set. Both can pulse together, and p_data is unchanged.
  - Next state is START (edge_cnt=0, configuration recaptured) if rxs==0, else IDLE.
- Pulse outputs are registered, high for exactly 1 cycle, and never overlap data_valid.
- Error flags are cleared on entry to START.
- All counter arithmetic is unsigned PRESC_WIDTH wide, with no overflow since P ≤ 63. bit_cnt is 4 bits.

Test Plan:
- P=8, par_en=0, stop2=0: send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> one data_valid pulse and p_data=0xA5. The pulse falls (2 sync + 8·9 + 5) cycles after the pin start edge, ±1 per alignment.
- P=16, par_en=1, par_typ=0: send 0x3C with parity bit 1 (wrong) -> par_error pulse, no data_valid, p_data holds its previous value. Resend with parity 0 -> data_valid and p_data=0x3C.
- P=16: rx low for 3 cycles, then high -> strt_glitch pulse at edge M+1=9 of START, return to IDLE, no other pulse.
- P=32, stop2=1: send 0x55 then 0xAA back-to-back with zero idle -> two data_valid pulses, p_data=0x55 then 0xAA. Repeat with the second stop bit forced 0 on frame 1 -> stop_error, then frame 2 is still received.
- DATA_WIDTH=5, P=5 (odd, M=2), odd parity: send 0x13 with parity 0 -> data_valid and p_data=0x13. Also P=2 -> behaves as P=4.
- Assert rst mid-DATA -> all outputs 0 immediately, busy=0, and the next clean frame 0x81 is received correctly.
